i2s_consumer_module: RTL

Audio consumer and I2S transmitter on the `mclk` domain (mclk = 256 × fs). It derives `bclk` (mclk/4, 64 bit-slots per frame) and `lrclk` (mclk/256) from a free-running frame counter. It issues `m_sample_index` to the sample producer, captures the producer's `p_sample_buffer` when `valid` is asserted, and serialises each captured sample MSB-first in Philips I2S format, duplicated on both channels. It is the consumer end of the `m_sample_index` / `p_sample_buffer` / `valid` interface used by the player and synth sources.

---
 rtl/i2s_consumer_module.sv | 122 ++++++++++++
 1 files changed

// File: rtl/i2s_consumer_module.sv
// I2S consumer: requests producer samples by index, double-buffers them and
// serialises each one MSB-first (Philips I2S) on both channels.
//
// Ports:
//   mclk, rst         - master clock (256 x fs), async active-high reset
//   enable            - playback enable, sampled at the frame boundary
//   m_sample_index    - index of the sample wanted for the next frame
//   p_sample_buffer   - producer sample, qualified by valid
//   valid             - p_sample_buffer holds the requested sample
//   bclk, lrclk       - I2S bit clock (mclk/4) and word select (mclk/256)
//   sdata             - I2S serial data
//   underrun          - one-cycle pulse when a frame starts with no sample
//   underrun_count    - saturating underrun counter
module i2s_consumer_module #(
  parameter int SAMPLE_BITS = 16,
  parameter int INDEX_BITS  = 8
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [INDEX_BITS-1:0]  m_sample_index,
  input  logic [SAMPLE_BITS-1:0] p_sample_buffer,
  input  logic                   valid,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   underrun,
  output logic [15:0]            underrun_count
);

  localparam logic [4:0] SB5 = 5'(SAMPLE_BITS);

  logic [7:0]             cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] play_q, play_d;
  logic [SAMPLE_BITS-1:0] next_q, next_d;
  logic                   have_next_q, have_next_d;
  logic [INDEX_BITS-1:0]  m_idx_q, m_idx_d;
  logic                   underrun_q, underrun_d;
  logic [15:0]            underrun_count_q, underrun_count_d;
  logic                   sdata_q, sdata_d;

  logic       boundary;
  logic [4:0] pos;
  logic [4:0] bit_sel;
  logic [31:0] play_w;

  assign boundary = (cnt_q == 8'hFF);
  assign play_w   = 32'(play_q);
  // Position inside the channel of the slot about to start.
  assign pos      = cnt_q[6:2] + 5'd1;
  assign bit_sel  = SB5 - pos;

  always_comb begin
    cnt_d            = cnt_q + 8'd1;
    next_d           = next_q;
    have_next_d      = have_next_q;
    play_d           = play_q;
    m_idx_d          = m_idx_q;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;
    sdata_d          = sdata_q;

    if (boundary) begin
      have_next_d = 1'b0;
    end else if (valid && !have_next_q) begin
      next_d      = p_sample_buffer;
      have_next_d = 1'b1;
    end

    if (boundary) begin
      play_d = '0;
      if (enable) begin
        m_idx_d = m_idx_q + INDEX_BITS'(1);
        if (have_next_q) begin
          play_d = next_q;
        end else begin
          underrun_d = 1'b1;
          if (underrun_count_q != 16'hFFFF)
            underrun_count_d = underrun_count_q + 16'd1;
        end
      end
    end

    // Update only as bclk falls; slot 0 of each channel stays 0 (I2S delay).
    if (cnt_q[1:0] == 2'b11) begin
      if (pos != 5'd0 && pos <= SB5)
        sdata_d = play_w[bit_sel];
      else
        sdata_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt_q            <= '0;
      play_q           <= '0;
      next_q           <= '0;
      have_next_q      <= 1'b0;
      m_idx_q          <= '0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
      sdata_q          <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      play_q           <= play_d;
      next_q           <= next_d;
      have_next_q      <= have_next_d;
      m_idx_q          <= m_idx_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
      sdata_q          <= sdata_d;
    end
  end

  assign bclk           = cnt_q[1];
  assign lrclk          = cnt_q[7];
  assign sdata          = sdata_q;
  assign m_sample_index = m_idx_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule
